// File: rtl/my_pkg.sv
// rtl/my_pkg.sv - shared types and constants for the I2C burst master
package my_pkg;

  typedef logic [7:0] byte_t;
  typedef logic [6:0] i2c_addr_t;

  localparam logic I2C_RD = 1'b1;
  localparam logic I2C_WR = 1'b0;

  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_ADDR, ST_ADDR_ACK, ST_WDATA,
    ST_WACK, ST_RDATA, ST_RACK, ST_STOP
  } i2c_state_t;

endpackage

// File: rtl/i2c_burst_master_if.sv
// rtl/i2c_burst_master_if.sv - controller-side byte-stream handshake of the I2C burst master
interface i2c_burst_master_if #(
  parameter int LEN_W = 5
);
  import my_pkg::*;

  logic             start;
  logic             rw;
  i2c_addr_t        dev_addr;
  logic [LEN_W-1:0] len;
  byte_t            wr_data;
  logic             wr_ready;
  byte_t            rd_data;
  logic             rd_valid;
  logic             busy;
  logic             done;
  logic             nack;

  modport master (
    output start, rw, dev_addr, len, wr_data,
    input  wr_ready, rd_data, rd_valid, busy, done, nack
  );

  modport slave (
    input  start, rw, dev_addr, len, wr_data,
    output wr_ready, rd_data, rd_valid, busy, done, nack
  );

endinterface

// File: rtl/i2c_burst_master_bit_timer.sv
// rtl/i2c_burst_master_bit_timer.sv - quarter-bit divider producing SCL phase strobes
module i2c_bit_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  output logic [1:0] q_phase,
  output logic       q_last,
  output logic       bit_end
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div;

  assign q_last  = (div == DW'(CLK_DIV - 1));
  assign bit_end = q_last && (q_phase == 2'd3);

  always_ff @(posedge clk) begin
    if (!reset_n || !en) begin
      div     <= '0;
      q_phase <= 2'd0;
    end else if (q_last) begin
      div     <= '0;
      q_phase <= q_phase + 2'd1;
    end else begin
      div <= div + DW'(1);
    end
  end

endmodule

// File: rtl/i2c_burst_master.sv
// rtl/i2c_burst_master.sv - I2C master doing write/read bursts to a 7-bit target
module i2c_burst_master
  import my_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int BURST_MAX = 16,
  parameter int LEN_W     = $clog2(BURST_MAX + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  i2c_burst_master_if.slave   bus,
  output logic                scl_oe,
  output logic                sda_oe,
  input  logic                sda_i
);
  localparam logic [3:0] IDLE     = ST_IDLE;
  localparam logic [3:0] START    = ST_START;
  localparam logic [3:0] ADDR     = ST_ADDR;
  localparam logic [3:0] ADDR_ACK = ST_ADDR_ACK;
  localparam logic [3:0] WDATA    = ST_WDATA;
  localparam logic [3:0] WACK     = ST_WACK;
  localparam logic [3:0] RDATA    = ST_RDATA;
  localparam logic [3:0] RACK     = ST_RACK;
  localparam logic [3:0] STOP     = ST_STOP;

  logic [3:0]       state;
  logic [1:0]       q_phase;
  logic             q_last;
  logic             bit_end;
  byte_t            shreg;
  logic [2:0]       bit_idx;
  logic [LEN_W-1:0] cnt;
  logic             ack_smp;
  logic             rw_q;
  logic             sda_pull;

  i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (bus.busy),
    .q_phase (q_phase),
    .q_last  (q_last),
    .bit_end (bit_end)
  );

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == STOP) && bit_end;
  assign scl_oe   = (state != IDLE) && (state != START) && !q_phase[1];

  // Value driven for the current data/ACK bit; the byte arrives in the wr_ready cycle itself.
  always_comb begin
    sda_pull = 1'b0;
    case (state)
      ADDR:    sda_pull = ~shreg[7];
      WDATA:   sda_pull = bus.wr_ready ? ~bus.wr_data[7] : ~shreg[7];
      RACK:    sda_pull = (cnt != '0);
      default: sda_pull = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      sda_oe       <= 1'b0;
      shreg        <= '0;
      bit_idx      <= 3'd7;
      cnt          <= '0;
      ack_smp      <= 1'b0;
      rw_q         <= I2C_WR;
      bus.nack     <= 1'b0;
      bus.wr_ready <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      bus.wr_ready <= 1'b0;
      bus.rd_valid <= 1'b0;
      if (bus.wr_ready)
        shreg <= bus.wr_data;

      if (q_last) begin
        if (q_phase == 2'd0 && state != IDLE && state != START)
          sda_oe <= (state == STOP) ? 1'b1 : sda_pull;
        if (q_phase == 2'd1 && state == START)
          sda_oe <= 1'b1;
        if (q_phase == 2'd2 && state == STOP)
          sda_oe <= 1'b0;
        if (q_phase == 2'd2) begin
          ack_smp <= sda_i;
          if (state == RDATA) begin
            shreg <= {shreg[6:0], sda_i};
            if (bit_idx == 3'd0) begin
              bus.rd_valid <= 1'b1;
              bus.rd_data  <= {shreg[6:0], sda_i};
            end
          end
        end
      end

      // bit_idx wraps 0 -> 7 by itself, so every byte starts at bit 7.
      case (state)
        IDLE: if (bus.start) begin
          state    <= START;
          rw_q     <= bus.rw;
          shreg    <= {bus.dev_addr, bus.rw};
          cnt      <= (bus.len > LEN_W'(BURST_MAX)) ? LEN_W'(BURST_MAX) : bus.len;
          bus.nack <= 1'b0;
        end
        START: if (bit_end) state <= ADDR;
        ADDR: if (bit_end) begin
          shreg   <= {shreg[6:0], 1'b0};
          bit_idx <= bit_idx - 3'd1;
          if (bit_idx == 3'd0) state <= ADDR_ACK;
        end
        ADDR_ACK: if (bit_end) begin
          if (ack_smp) begin
            bus.nack <= 1'b1;
            state    <= STOP;
          end else if (cnt == '0) begin
            state <= STOP;
          end else if (rw_q == I2C_RD) begin
            state <= RDATA;
          end else begin
            state        <= WDATA;
            bus.wr_ready <= 1'b1;
          end
        end
        WDATA: if (bit_end) begin
          shreg   <= {shreg[6:0], 1'b0};
          bit_idx <= bit_idx - 3'd1;
          if (bit_idx == 3'd0) begin
            state <= WACK;
            cnt   <= cnt - LEN_W'(1);
          end
        end
        WACK: if (bit_end) begin
          if (ack_smp) begin
            bus.nack <= 1'b1;
            state    <= STOP;
          end else if (cnt == '0) begin
            state <= STOP;
          end else begin
            state        <= WDATA;
            bus.wr_ready <= 1'b1;
          end
        end
        RDATA: if (bit_end) begin
          bit_idx <= bit_idx - 3'd1;
          if (bit_idx == 3'd0) begin
            state <= RACK;
            cnt   <= cnt - LEN_W'(1);
          end
        end
        RACK: if (bit_end) state <= (cnt == '0) ? STOP : RDATA;
        STOP: if (bit_end) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_burst_master.sv
// tb/tb_i2c_burst_master.sv - scoreboard bench with a behavioural I2C target on the bus
module tb_i2c_burst_master;
  import my_pkg::*;

  localparam int CLK_DIV   = 2;
  localparam int BURST_MAX = 16;
  localparam int LEN_W     = 5;
  localparam int EV_START  = 1000;
  localparam int EV_STOP   = 1001;

  typedef struct { int lat; int nk; int wrs; } done_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic scl_oe, sda_oe, sda_i;
  logic tgt_pull = 1'b0;

  i2c_burst_master_if #(.LEN_W(LEN_W)) ifc();

  i2c_burst_master #(.CLK_DIV(CLK_DIV), .BURST_MAX(BURST_MAX), .LEN_W(LEN_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc),
    .scl_oe  (scl_oe),
    .sda_oe  (sda_oe),
    .sda_i   (sda_i)
  );

  assign sda_i = !(sda_oe || tgt_pull);
  always #5 clk = ~clk;

  int vecs = 0;
  int miscompares = 0;
  int cyc = 0;
  int t_acc = 0;
  int wr_cnt = 0;
  bit mon_on = 1'b1;
  bit tgt_rst = 1'b0;
  bit anack_cfg = 1'b0;
  int wnack_cfg = -1;
  int exp_bus[$];
  byte_t exp_rd[$];
  done_t exp_done[$];
  byte_t wq[$];
  byte_t rq[$];

  function automatic void check(string name, int act, int exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail_unexp(string name, int act);
    vecs++;
    miscompares++;
    $display("FAIL %s: unexpected event 0x%0h with nothing expected", name, act);
  endfunction

  function automatic void bus_obs(int v);
    if (!mon_on) return;
    if (exp_bus.size() == 0) fail_unexp("bus_event", v);
    else check("bus_event", v, exp_bus.pop_front());
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Cycle index 1 is the first cycle after the accept edge.
  initial forever begin
    done_t e;
    @(negedge clk);
    if (ifc.start && !ifc.busy && reset_n) t_acc = cyc + 1;
    if (mon_on && ifc.rd_valid) begin
      if (exp_rd.size() == 0) fail_unexp("rd_valid", int'(ifc.rd_data));
      else check("rd_data", int'(ifc.rd_data), int'(exp_rd.pop_front()));
    end
    if (mon_on && ifc.done) begin
      if (exp_done.size() == 0) fail_unexp("done", cyc - t_acc + 1);
      else begin
        e = exp_done.pop_front();
        check("done_cycle", cyc - t_acc + 1, e.lat);
        check("nack", int'(ifc.nack), e.nk);
        check("wr_ready_count", wr_cnt, e.wrs);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (ifc.wr_ready) begin
      @(posedge clk);
      #1;
      wr_cnt++;
      ifc.wr_data = (wr_cnt < wq.size()) ? wq[wr_cnt] : 8'h00;
    end
  end

  // Target: decodes START/STOP and bits on SCL rise, changes SDA only while SCL is low.
  initial begin : target
    bit pscl, psda, scl, sda, ackv, is_addr, tx_mode;
    int bitcnt, ridx, widx;
    byte_t sh, txb;
    pscl = 1'b1; psda = 1'b1; bitcnt = 9; ridx = 0; widx = 0;
    is_addr = 1'b0; tx_mode = 1'b0; ackv = 1'b1; sh = '0; txb = '0;
    forever begin
      @(negedge clk);
      if (tgt_rst) begin
        tgt_rst = 1'b0; tgt_pull = 1'b0; bitcnt = 9; is_addr = 1'b0; tx_mode = 1'b0;
      end
      scl = !scl_oe;
      sda = !(sda_oe || tgt_pull);
      if (pscl && scl && psda && !sda) begin
        bus_obs(EV_START);
        bitcnt = 0; is_addr = 1'b1; tx_mode = 1'b0; ridx = 0; widx = 0;
      end else if (pscl && scl && !psda && sda) begin
        bus_obs(EV_STOP);
        tgt_pull = 1'b0; bitcnt = 9;
      end else if (!pscl && scl) begin
        if (bitcnt < 8) begin
          sh = {sh[6:0], sda};
          bitcnt++;
        end else if (bitcnt == 8) begin
          ackv = sda;
          bus_obs(int'({ackv, sh}));
          bitcnt = 9;
        end
      end else if (pscl && !scl) begin
        if (bitcnt == 8) begin
          if (tx_mode) tgt_pull = 1'b0;
          else if (is_addr) tgt_pull = !anack_cfg;
          else begin
            tgt_pull = (widx != wnack_cfg);
            widx++;
          end
        end else if (bitcnt == 9 && (is_addr || tx_mode || tgt_pull)) begin
          bitcnt = 0;
          if (is_addr) begin
            is_addr = 1'b0;
            tx_mode = sh[0] && !ackv;
          end else if (tx_mode) tx_mode = !ackv;
          if (tx_mode) begin
            txb = (ridx < rq.size()) ? rq[ridx] : 8'hFF;
            ridx++;
            tgt_pull = !txb[7];
          end else tgt_pull = 1'b0;
        end else if (tx_mode && bitcnt > 0 && bitcnt < 8) begin
          tgt_pull = !txb[7 - bitcnt];
        end
      end
      pscl = scl;
      psda = !(sda_oe || tgt_pull);
    end
  end

  task automatic xfer(bit rw, bit [6:0] a, int len, bit anack, int wnack, bit poke);
    int n_eff, n, k;
    bit nk;
    n_eff = (len > BURST_MAX) ? BURST_MAX : len;
    while (wq.size() < n_eff) wq.push_back(byte_t'($urandom));
    while (rq.size() < n_eff) rq.push_back(byte_t'($urandom));
    anack_cfg = anack;
    wnack_cfg = wnack;
    nk = anack || (!rw && wnack >= 0 && wnack < n_eff);
    n = 0;
    exp_bus.push_back(EV_START);
    exp_bus.push_back(int'({anack, a, rw}));
    if (!anack) begin
      for (int i = 0; i < n_eff; i++) begin
        n++;
        if (rw) begin
          exp_bus.push_back(int'({i == n_eff - 1, rq[i]}));
          exp_rd.push_back(rq[i]);
        end else begin
          exp_bus.push_back(int'({i == wnack, wq[i]}));
          if (i == wnack) break;
        end
      end
    end
    exp_bus.push_back(EV_STOP);
    exp_done.push_back('{(11 + 9 * n) * 4 * CLK_DIV, int'(nk), rw ? 0 : n});

    wr_cnt = 0;
    ifc.wr_data = (wq.size() > 0) ? wq[0] : 8'h00;
    @(posedge clk); #1;
    ifc.rw = rw; ifc.dev_addr = a; ifc.len = LEN_W'(len); ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    if (poke) begin
      repeat (20) @(posedge clk);
      #1;
      ifc.start = 1'b1; ifc.rw = ~rw; ifc.len = LEN_W'(5); ifc.dev_addr = 7'h7F;
      @(posedge clk); #1;
      ifc.start = 1'b0;
    end
    k = 0;
    while (ifc.busy && k < 4000) begin
      @(posedge clk); #1;
      k++;
    end
    if (ifc.busy) fail_unexp("timeout_busy", k);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    bit quiet;
    int rlen;
    bit rrw;
    ifc.start = 1'b0; ifc.rw = 1'b0; ifc.dev_addr = '0; ifc.len = '0; ifc.wr_data = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl_oe", int'(scl_oe), 0);
    check("rst_sda_oe", int'(sda_oe), 0);
    check("rst_busy", int'(ifc.busy), 0);
    check("rst_done", int'(ifc.done), 0);
    check("rst_nack", int'(ifc.nack), 0);
    check("rst_wr_ready", int'(ifc.wr_ready), 0);
    check("rst_rd_valid", int'(ifc.rd_valid), 0);
    check("rst_rd_data", int'(ifc.rd_data), 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    wq = '{8'hA5, 8'h3C};
    xfer(1'b0, 7'h50, 2, 1'b0, -1, 1'b0);
    rq = '{8'h11, 8'h22, 8'h33};
    xfer(1'b1, 7'h50, 3, 1'b0, -1, 1'b0);
    wq.delete(); rq.delete();
    xfer(1'b0, 7'h50, 4, 1'b1, -1, 1'b0);
    wq.delete();
    xfer(1'b0, 7'h2A, 4, 1'b0, 1, 1'b0);
    wq.delete();
    xfer(1'b0, 7'h33, 0, 1'b0, -1, 1'b1);

    // Abort a read mid-byte with a one-cycle reset.
    mon_on = 1'b0;
    rq = '{8'h00, 8'h00, 8'h00};
    anack_cfg = 1'b0; wnack_cfg = -1;
    @(posedge clk); #1;
    ifc.rw = 1'b1; ifc.dev_addr = 7'h50; ifc.len = LEN_W'(3); ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("mid_read_busy", int'(ifc.busy), 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("abort_scl_oe", int'(scl_oe), 0);
    check("abort_sda_oe", int'(sda_oe), 0);
    check("abort_busy", int'(ifc.busy), 0);
    tgt_rst = 1'b1;
    quiet = 1'b1;
    repeat (60) begin
      @(posedge clk); #1;
      if (ifc.done || ifc.busy) quiet = 1'b0;
    end
    check("abort_no_done", int'(quiet), 1);
    mon_on = 1'b1;
    rq.delete();
    xfer(1'b1, 7'h50, 3, 1'b0, -1, 1'b0);

    wq.delete();
    xfer(1'b0, 7'h11, 20, 1'b0, -1, 1'b0);
    rq.delete();
    xfer(1'b1, 7'h12, 31, 1'b0, -1, 1'b0);

    for (int t = 0; t < 12; t++) begin
      rlen = $urandom_range(0, BURST_MAX);
      rrw = (rlen == 0) ? 1'b0 : 1'(($urandom % 2));
      wq.delete(); rq.delete();
      xfer(rrw, 7'($urandom), rlen, ($urandom % 6) == 0,
           (($urandom % 3) == 0) ? $urandom_range(0, rlen) : -1, ($urandom % 4) == 0);
    end

    check("bus_queue_drained", exp_bus.size(), 0);
    check("rd_queue_drained", exp_rd.size(), 0);
    check("done_queue_drained", exp_done.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_burst_master.md
# i2c_burst_master

Parametrised I2C master for the memory subsystem. Performs single- or multi-byte write and read bursts to a 7-bit-addressed target with a programmable SCL divider and open-drain pad controls. Handles master ACK/NACK on reads, detects target NACK, and generates clean START/STOP framing. Sits between the subsystem controller (byte-stream handshake) and the SCL/SDA pads.

## Interface

- `CLK_DIV`, default 4: `clk` cycles per SCL quarter-bit; ≥1.
- `BURST_MAX`, default 16: maximum bytes per transfer.
- `LEN_W`, default `$clog2(BURST_MAX+1)`: width of `len`.

Ports:

- `clk`, in, 1: clock.
- `reset_n`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: request a transfer; sampled only in IDLE.
- `rw`, in, 1: 1 = read, 0 = write.
- `dev_addr`, in, 7: target address.
- `len`, in, LEN_W: byte count, 0..BURST_MAX; 0 = address-only probe.
- `wr_data`, in, 8: write byte; must be valid in the `wr_ready` cycle.
- `wr_ready`, out, 1: 1-cycle pulse; block latches `wr_data` this cycle.
- `rd_data`, out, 8: last received byte; held until the next byte.
- `rd_valid`, out, 1: 1-cycle pulse with each received byte.
- `busy`, out, 1: transfer in progress.
- `done`, out, 1: 1-cycle pulse at end of STOP.
- `nack`, out, 1: sticky target-NACK flag; cleared on accepted `start`.
- `scl_oe`, out, 1: 1 = pull SCL low, 0 = release.
- `sda_oe`, out, 1: 1 = pull SDA low, 0 = release.
- `sda_i`, in, 1: SDA pad input.

## Operation

- Reset values:
  - `scl_oe`, `sda_oe`, `busy`, `done`, `nack`, `wr_ready`, `rd_valid` = 0.
  - `rd_data` = 8'h00.
  - State = IDLE.
- Reset mid-transfer:
  - Both lines are released on the next edge.
  - No STOP is generated and no `done` pulse is issued.
- `start` in IDLE:
  - Latches `rw`, `dev_addr`, `len` (clamped to BURST_MAX) and clears `nack`.
  - `start` while `busy` is ignored.
- States: IDLE → START → ADDR → ADDR_ACK → {WDATA ↔ WACK | RDATA ↔ RACK} → STOP → IDLE.
- ADDR: shifts `{dev_addr, rw}` out MSB first, 8 bits.
- ADDR_ACK: SDA is released and `sda_i` is sampled.
  - 1 (NACK) → set `nack`, go to STOP.
  - `len` = 0 → STOP.
  - Otherwise → WDATA or RDATA according to `rw`.
- WDATA:
  - `wr_ready` pulses at the first cycle of the byte's bit 7.
  - The latched byte is shifted out MSB first.
- WACK:
  - NACK → set `nack`, STOP, remaining bytes dropped.
  - ACK with the last byte sent → STOP.
  - Otherwise → WDATA.
- RDATA:
  - SDA is released; 8 bits are sampled MSB first.
  - `rd_valid` pulses the cycle after bit 0 is sampled.
- RACK:
  - Master drives ACK (`sda_oe` = 1) on every byte except the last.
  - On the last byte it drives NACK (`sda_oe` = 0), then STOP.
- Byte counter: counts down from `len`, with no wrap-around; it reaches 0 exactly at the last byte.

## Timing

- Bit period = 4 quarters Q0..Q3, each `CLK_DIV` cycles.
- Data/ACK bits:
  - Q0: SCL low, SDA holds its previous value.
  - Q1: SCL low, SDA updated.
  - Q2–Q3: SCL released.
  - `sda_i` is sampled on the last cycle of Q2.
- START bit:
  - Q0–Q1: both lines released.
  - Q2–Q3: SDA low, SCL released.
- STOP bit:
  - Q0: SCL low.
  - Q1: SCL low, SDA low.
  - Q2: SCL released, SDA low.
  - Q3: SDA released.
  - `done` pulses on the last cycle of Q3; `busy` falls on the next cycle.
- `busy` rises the cycle after `start` is accepted.
- `done` arrives (11 + 9·N)·4·CLK_DIV cycles after the accept edge, where N = bytes actually transferred.
- A NACK on the address gives N = 0.
- No clock stretching: SCL is never read back.
- `start` asserted in the same cycle `done` pulses is ignored; `start` is accepted from the first IDLE cycle.

## Structure

- Shared package `my_pkg` holds:
  - `i2c_state_t` enum.
  - `I2C_RD`/`I2C_WR` constants.
  - `i2c_addr_t` (7-bit) typedef.
  - The existing `byte_t` typedef.
- Sub-module `i2c_bit_timer`:
  - Divider counter modulo `CLK_DIV`, plus 2-bit quarter counter.
  - Outputs `q_phase[1:0]`, `q_last` (last cycle of the quarter) and `bit_end` (last cycle of Q3).
  - Enabled by `busy`; cleared by reset.
- The top level holds the FSM, shift register, bit index and byte counter.

## Test plan

- **Write 2 bytes** (CLK_DIV=2, write to 0x50, len=2, bytes 0xA5/0x3C, target ACKs all):
  - Bus carries START, 0xA0, ACK, 0xA5, ACK, 0x3C, ACK, STOP.
  - Two `wr_ready` pulses.
  - `done` at cycle 232; `nack` = 0.
- **Read 3 bytes** (read from 0x50, len=3, target returns 0x11/0x22/0x33):
  - Address byte 0xA1.
  - `rd_valid` ×3 with matching `rd_data`.
  - Master ACK, ACK, then NACK.
  - STOP; `done` at (11+27)·4·CLK_DIV cycles.
- **Address NACK** (`sda_i` high at address ACK, len=4):
  - `nack` = 1, STOP issued, no `wr_ready`.
  - `done` at 88 cycles (CLK_DIV=2).
- **Write NACK on byte 2 of 4**:
  - Exactly 2 `wr_ready` pulses, `nack` = 1.
  - STOP follows the second ACK slot.
- **Probe and busy start** (len=0, ACK; plus `start` pulsed while `busy`):
  - Address only, then STOP.
  - The second `start` is ignored; `nack` = 0.
- **Reset mid-RDATA** (`reset_n` low 1 cycle):
  - Next cycle: `scl_oe` = `sda_oe` = `busy` = 0, state IDLE, no `done`.
  - A new `start` afterwards completes normally.
